// File: rtl/grid_loader.sv
// grid_loader: streams an ASCII '@'/'.' puzzle text into a WIDTH x DEPTH bit grid.
// Optional feature: define GRID_LOADER_CR_SKIP_EN to accept and ignore carriage returns (0x0D).
module grid_loader #(
   parameter int WIDTH = 16,
   parameter int DEPTH = 16
) (
   input  logic                               clk,
   input  logic                               reset,
   input  logic                               clear,
   input  logic                               in_valid,
   input  logic [7:0]                         in_char,
   input  logic                               in_last,
   output logic                               in_ready,
   output logic [WIDTH-1:0]                   mat [DEPTH-1:0],
   output logic                               load,
   output logic                               grid_valid,
   output logic [$clog2(DEPTH+1)-1:0]         rows,
   output logic [$clog2(WIDTH*DEPTH+1)-1:0]   cell_count,
   output logic                               err
);

   localparam int RW = $clog2(DEPTH+1);
   localparam int CW = $clog2(WIDTH+1);
   localparam int NW = $clog2(WIDTH*DEPTH+1);

   typedef enum logic [1:0] {
      S_ACCEPT = 2'd0,
      S_DONE   = 2'd1,
      S_ERR    = 2'd2
   } state_t;

   state_t            r_state;
   state_t            w_state_nx;
   logic [WIDTH-1:0]  r_mat [DEPTH-1:0];
   logic [RW-1:0]     r_rows;
   logic [RW-1:0]     w_rows_nx;
   logic [CW-1:0]     r_col;
   logic [CW-1:0]     w_col_nx;
   logic [CW-1:0]     w_col_adv;
   logic [NW-1:0]     r_cnt;
   logic [NW-1:0]     w_cnt_nx;
   logic              r_load;
   logic              w_load_nx;
   logic              w_set;
   logic              w_hs;
   logic              w_is_at;
   logic              w_is_dot;
   logic              w_is_nl;
   logic              w_cr_ok;
   logic              w_legal;
   logic              w_close;
   logic              w_done;

   assign w_hs     = in_valid && (r_state == S_ACCEPT);
   assign w_is_at  = (in_char == 8'h40);
   assign w_is_dot = (in_char == 8'h2E);
   assign w_is_nl  = (in_char == 8'h0A);
`ifdef GRID_LOADER_CR_SKIP_EN
   assign w_cr_ok  = (in_char == 8'h0D);
`else
   assign w_cr_ok  = 1'b0;
`endif
   assign w_legal  = ((w_is_at || w_is_dot) && (r_col < CW'(WIDTH))) || w_is_nl || w_cr_ok;

   // A row closes on a newline, or on the final character when the row holds anything.
   assign w_col_adv = (w_is_at || w_is_dot) ? (r_col + CW'(1)) : r_col;
   assign w_close   = (w_is_nl || in_last) && (w_col_adv != {CW{1'b0}});
   assign w_done    = in_last || (w_is_nl && w_close && ((r_rows + RW'(1)) == RW'(DEPTH)));

   // Next-state and next-datapath decode for one handshake
   always_comb begin
      w_state_nx = r_state;
      w_rows_nx  = r_rows;
      w_col_nx   = r_col;
      w_cnt_nx   = r_cnt;
      w_set      = 1'b0;
      w_load_nx  = 1'b0;
      if (w_hs) begin
         if (!w_legal) begin
            w_state_nx = S_ERR;
         end else begin
            w_set     = w_is_at;
            w_cnt_nx  = w_is_at ? (r_cnt + NW'(1)) : r_cnt;
            w_col_nx  = w_close ? {CW{1'b0}} : w_col_adv;
            w_rows_nx = w_close ? (r_rows + RW'(1)) : r_rows;
            if (w_done) begin
               w_state_nx = S_DONE;
               w_load_nx  = 1'b1;
            end else begin
               w_state_nx = S_ACCEPT;
            end
         end
      end else begin
         w_state_nx = r_state;
      end
   end

   // State register; reset outranks clear, both return to ACCEPT
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= S_ACCEPT;
      end else if (clear) begin
         r_state <= S_ACCEPT;
      end else begin
         r_state <= w_state_nx;
      end
   end

   // Grid, counters and load strobe
   always_ff @(posedge clk) begin
      if (reset || clear) begin
         r_rows <= {RW{1'b0}};
         r_col  <= {CW{1'b0}};
         r_cnt  <= {NW{1'b0}};
         r_load <= 1'b0;
         for (int r = 0; r < DEPTH; r++) begin
            r_mat[r] <= {WIDTH{1'b0}};
         end
      end else begin
         r_rows <= w_rows_nx;
         r_col  <= w_col_nx;
         r_cnt  <= w_cnt_nx;
         r_load <= w_load_nx;
         for (int r = 0; r < DEPTH; r++) begin
            for (int c = 0; c < WIDTH; c++) begin
               if (w_set && (r_rows == RW'(r)) && (r_col == CW'(c))) begin
                  r_mat[r][c] <= 1'b1;
               end
            end
         end
      end
   end

   assign in_ready   = (r_state == S_ACCEPT);
   assign grid_valid = (r_state == S_DONE);
   assign err        = (r_state == S_ERR);
   assign load       = r_load;
   assign rows       = r_rows;
   assign cell_count = r_cnt;
   assign mat        = r_mat;

endmodule

// File: tb/tb_grid_loader.sv
// Self-checking bench for grid_loader (WIDTH=4, DEPTH=3): table vectors, corner sequences,
// and random streams checked against a text-based reference model.
module tb_grid_loader;

   localparam int W = 4;
   localparam int D = 3;
`ifdef GRID_LOADER_CR_SKIP_EN
   localparam bit CR_OK = 1'b1;
`else
   localparam bit CR_OK = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       clear = 1'b0;
   logic       in_valid = 1'b0;
   logic [7:0] in_char = 8'h00;
   logic       in_last = 1'b0;
   logic       in_ready;
   logic [3:0] mat [2:0];
   logic       load;
   logic       grid_valid;
   logic [1:0] rows;
   logic [3:0] cell_count;
   logic       err;

   grid_loader #(.WIDTH(W), .DEPTH(D)) dut (
      .clk(clk), .reset(reset), .clear(clear), .in_valid(in_valid),
      .in_char(in_char), .in_last(in_last), .in_ready(in_ready), .mat(mat),
      .load(load), .grid_valid(grid_valid), .rows(rows),
      .cell_count(cell_count), .err(err)
   );

   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;

   // Reference model: the accepted text plus a state (0 accept, 1 done, 2 error).
   byte unsigned m_text[$];
   int           m_state = 0;
   bit           m_load  = 1'b0;
   bit [3:0]     g_mat [3];
   int           g_rows, g_col, g_cnt;

   function automatic void rebuild(bit fin);
      g_rows = 0; g_col = 0; g_cnt = 0;
      for (int i = 0; i < D; i++) g_mat[i] = 4'b0000;
      foreach (m_text[k]) begin
         case (m_text[k])
            8'h40: begin
               if (g_rows < D && g_col < W) g_mat[g_rows][g_col] = 1'b1;
               g_cnt++; g_col++;
            end
            8'h2E: g_col++;
            8'h0A: if (g_col > 0) begin g_rows++; g_col = 0; end
            default: ;
         endcase
      end
      if (fin && g_col > 0) begin g_rows++; g_col = 0; end
   endfunction

   function automatic void model(bit v, byte unsigned ch, bit last, bit clr, bit rst);
      bit is_cell, legal;
      m_load = 1'b0;
      if (rst || clr) begin
         m_text.delete();
         m_state = 0;
      end else if (v && m_state == 0) begin
         rebuild(1'b0);
         is_cell = (ch == 8'h40) || (ch == 8'h2E);
         legal = (is_cell && g_col < W) || (ch == 8'h0A) || (CR_OK && ch == 8'h0D);
         if (!legal) begin
            m_state = 2;
         end else begin
            m_text.push_back(ch);
            rebuild(1'b0);
            if (last || (ch == 8'h0A && g_rows == D)) begin
               m_state = 1;
               m_load  = 1'b1;
            end
         end
      end
      rebuild(m_state == 1);
   endfunction

   task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic check_all(string tag);
      chk({tag, ":in_ready"}, in_ready, (m_state == 0));
      chk({tag, ":err"}, err, (m_state == 2));
      chk({tag, ":grid_valid"}, grid_valid, (m_state == 1));
      chk({tag, ":load"}, load, m_load);
      chk({tag, ":rows"}, rows, g_rows);
      chk({tag, ":cell_count"}, cell_count, g_cnt);
      for (int r = 0; r < D; r++) chk($sformatf("%s:mat%0d", tag, r), mat[r], g_mat[r]);
   endtask

   task automatic step(string tag, bit v, byte unsigned ch, bit last, bit clr, bit rst);
      reset = rst; clear = clr; in_valid = v; in_char = ch; in_last = last;
      @(posedge clk);
      model(v, ch, last, clr, rst);
      #1;
      reset = 1'b0; clear = 1'b0; in_valid = 1'b0; in_last = 1'b0;
      check_all(tag);
   endtask

   task automatic send_str(string tag, string s, bit last_on_final);
      for (int k = 0; k < s.len(); k++)
         step(tag, 1'b1, s[k], last_on_final && (k == s.len() - 1), 1'b0, 1'b0);
   endtask

   typedef struct {
      string    txt;
      bit       lst;
      int       st;
      int       nrows;
      int       ncnt;
      bit [3:0] m0, m1, m2;
   } vec_t;

   vec_t tbl[6];

   initial begin
      tbl[0] = '{"@@.@\n.@@.\n@..@\n", 1'b0, 1, 3, 7, 4'b1011, 4'b0110, 4'b1001};
      tbl[1] = '{"@.\n\n@@",           1'b1, 1, 2, 3, 4'b0001, 4'b0011, 4'b0000};
      tbl[2] = '{"@@@@@",              1'b0, 2, 0, 4, 4'b1111, 4'b0000, 4'b0000};
      tbl[3] = '{"@.#",                1'b0, 2, 0, 1, 4'b0001, 4'b0000, 4'b0000};
      tbl[4] = '{"..@\n",              1'b1, 1, 1, 1, 4'b0100, 4'b0000, 4'b0000};
      tbl[5] = '{"@\n\n\n.@\n@@@@\n",  1'b0, 1, 3, 6, 4'b0001, 4'b0010, 4'b1111};

      step("reset", 1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
      chk("reset_ready", in_ready, 1'b1);

      for (int i = 0; i < 6; i++) begin
         step("tbl_clr", 1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
         send_str($sformatf("tbl%0d", i), tbl[i].txt, tbl[i].lst);
         step($sformatf("tbl%0d_idle", i), 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
         chk($sformatf("tbl%0d_err", i), err, (tbl[i].st == 2));
         chk($sformatf("tbl%0d_done", i), grid_valid, (tbl[i].st == 1));
         chk($sformatf("tbl%0d_rows", i), rows, tbl[i].nrows);
         chk($sformatf("tbl%0d_cnt", i), cell_count, tbl[i].ncnt);
         chk($sformatf("tbl%0d_m0", i), mat[0], tbl[i].m0);
         chk($sformatf("tbl%0d_m1", i), mat[1], tbl[i].m1);
         chk($sformatf("tbl%0d_m2", i), mat[2], tbl[i].m2);
      end

      // Error then clear: grid empties, ready next cycle.
      step("e_clr", 1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
      send_str("e_seq", "@.#", 1'b0);
      chk("e_err", err, 1'b1);
      step("e_clear", 1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
      chk("e_ready", in_ready, 1'b1);
      chk("e_cnt", cell_count, 4'd0);
      chk("e_m0", mat[0], 4'b0000);

      // Illegal char carrying in_last goes to ERR with no load pulse.
      send_str("el", "@#", 1'b1);
      chk("el_err", err, 1'b1);
      chk("el_load", load, 1'b0);

      // Completed grid ignores further traffic; load lasts exactly one cycle.
      step("d_clr", 1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
      send_str("d_seq", tbl[0].txt, 1'b0);
      chk("d_load_hi", load, 1'b1);
      step("d_more", 1'b1, 8'h40, 1'b0, 1'b0, 1'b0);
      chk("d_load_lo", load, 1'b0);
      chk("d_m0", mat[0], 4'b1011);

      // Clear wins over a simultaneous handshake; reset wins over clear.
      step("c_clr", 1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
      send_str("c_seq", "@@", 1'b0);
      step("c_beat", 1'b1, 8'h40, 1'b0, 1'b1, 1'b0);
      chk("c_cnt", cell_count, 4'd0);
      send_str("c_seq2", "@.", 1'b0);
      step("r_beat", 1'b1, 8'h40, 1'b1, 1'b1, 1'b1);
      chk("r_done", grid_valid, 1'b0);
      chk("r_m0", mat[0], 4'b0000);

      // Reset mid-load then restream the full grid.
      send_str("m_seq", "@@.@\n.@@.\n", 1'b0);
      step("m_reset", 1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
      chk("m_rows0", rows, 2'd0);
      send_str("m_re", tbl[0].txt, 1'b0);
      chk("m_rows", rows, 2'd3);
      chk("m_cnt", cell_count, 4'd7);
      chk("m_m1", mat[1], 4'b0110);

      // Carriage return handling with in_valid held across the sequence.
      step("cr_clr", 1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
      step("cr_a", 1'b1, 8'h40, 1'b0, 1'b0, 1'b0);
      step("cr_r", 1'b1, 8'h0D, 1'b0, 1'b0, 1'b0);
      step("cr_n", 1'b1, 8'h0A, 1'b0, 1'b0, 1'b0);
      if (CR_OK) begin
         chk("cr_rows", rows, 2'd1);
         chk("cr_err", err, 1'b0);
      end else begin
         chk("cr_rows", rows, 2'd0);
         chk("cr_err", err, 1'b1);
      end
      chk("cr_m0", mat[0], 4'b0001);

      // Random streams against the model.
      step("rnd_clr", 1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
      for (int n = 0; n < 400; n++) begin
         int          pick;
         byte unsigned ch;
         bit          v, lst, clr;
         pick = $urandom_range(0, 9);
         if (pick <= 3)      ch = 8'h40;
         else if (pick <= 6) ch = 8'h2E;
         else if (pick <= 8) ch = 8'h0A;
         else                ch = ($urandom_range(0, 1) == 0) ? 8'h23 : 8'h0D;
         v   = ($urandom_range(0, 3) != 0);
         lst = ($urandom_range(0, 15) == 0);
         clr = ($urandom_range(0, 49) == 0) || (m_state != 0 && $urandom_range(0, 3) == 0);
         step("rnd", v, ch, lst, clr, 1'b0);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/grid_loader.md
GRID_LOADER -- requirements
Module: grid_loader

Interface
REQ-001 SHALL have parameter WIDTH, default 16, meaning grid columns (cells per row).
REQ-002 SHALL have parameter DEPTH, default 16, meaning grid rows.
REQ-003 SHALL have port clk  input  1  sole clock, all state updates on rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port clear  input  1  synchronous restart: empties grid, returns to ACCEPT.
REQ-006 SHALL have port in_valid  input  1  character present on in_char.
REQ-007 SHALL have port in_char  input  8  ASCII character of the puzzle text.
REQ-008 SHALL have port in_last  input  1  marks in_char as the final character of the file.
REQ-009 SHALL have port in_ready  output  1  loader can accept a character this cycle.
REQ-010 SHALL have port mat  output  WIDTH x DEPTH unpacked array [WIDTH-1:0] [DEPTH-1:0]  loaded grid, 1=paper, 0=empty.
REQ-011 SHALL have port load  output  1  one-cycle pulse when grid complete; drives downstream reset/load strobe.
REQ-012 SHALL have port grid_valid  output  1  level, high while in DONE.
REQ-013 SHALL have port rows  output  $clog2(DEPTH+1)  rows completed so far.
REQ-014 SHALL have port cell_count  output  $clog2(WIDTH*DEPTH+1)  number of 1 cells stored.
REQ-015 SHALL have port err  output  1  level, high while in ERR.

Function
REQ-016 SHALL implement states ACCEPT, DONE, ERR; in_ready=1 only in ACCEPT.
REQ-017 Handshake SHALL occur on a rising edge where in_valid && in_ready; no other cycle changes mat, rows, col or cell_count.
REQ-018 '@' (0x40) SHALL set mat[row][col]=1, increment col and cell_count; '.' (0x2E) SHALL leave cell 0, increment col.
REQ-019 Column c of a row SHALL map to bit c of mat[row]; rows shorter than WIDTH leave remaining bits 0.
REQ-020 '\n' (0x0A) with col>0 SHALL increment rows, reset col to 0; '\n' with col==0 (blank line) SHALL be ignored.
REQ-021 '@' or '.' arriving with col==WIDTH SHALL enter ERR (row overflow), cell unchanged.
REQ-022 Any character other than '@', '.', '\n' (subject to REQ-033) SHALL enter ERR.
REQ-023 Grid SHALL complete on handshake of the '\n' that makes rows==DEPTH, or on any legal handshake with in_last=1 (a partial final row counts as a row).
REQ-024 Completion SHALL move to DONE on that edge; load SHALL be high for exactly the following cycle; grid_valid SHALL stay high until reset/clear.
REQ-025 Illegal character with in_last=1 SHALL enter ERR, not DONE; load never pulses from ERR.
REQ-026 mat, rows, cell_count SHALL hold their values in DONE and ERR.
REQ-027 clear in any state SHALL, on that edge, zero mat, rows, col, cell_count, load and return to ACCEPT; clear beats a simultaneous handshake.
REQ-028 cell_count SHALL equal the popcount of mat at all times; counters SHALL not wrap (bounded by REQ-021/023).

Reset
REQ-029 reset SHALL take priority over clear and handshake.
REQ-030 On reset: state=ACCEPT, mat all 0, rows=0, col=0, cell_count=0, load=0, grid_valid=0, err=0, in_ready=1 the following cycle.
REQ-031 Reset mid-load SHALL discard all partial grid contents.

Configuration
REQ-032 Macro GRID_LOADER_CR_SKIP_EN SHALL select carriage-return handling.
REQ-033 With GRID_LOADER_CR_SKIP_EN defined, 0x0D SHALL be accepted and ignored (no col/row change; with in_last=1 it still completes); undefined, 0x0D SHALL enter ERR.

Verification
REQ-034 WIDTH=4, DEPTH=3; send "@@.@\n.@@.\n@..@\n" -> load pulse one cycle after final '\n', mat[0]=4'b1011, mat[1]=4'b0110, mat[2]=4'b1001, rows=3, cell_count=7.
REQ-035 Send "@.\n\n@@" with in_last on last '@' -> DONE, rows=2, mat[0]=4'b0001, mat[1]=4'b0011, mat[2]=0, cell_count=3.
REQ-036 Send "@@@@@" (5 chars, WIDTH=4) -> ERR after 5th handshake, in_ready=0, mat[0]=4'b1111, load never high.
REQ-037 Send "@.#" -> err=1 after '#'; then clear -> mat all 0, cell_count=0, in_ready=1 next cycle.
REQ-038 Send "@\r\n" with in_valid held high -> macro defined: rows=1, mat[0]=4'b0001; undefined: ERR on '\r'.
REQ-039 Assert reset after 2nd row of REQ-034 stream -> all outputs at REQ-030 values; restreaming full grid reproduces REQ-034 result.
